// File: rtl/mac_column_sequencer.sv
// Sequences one bit-column MAC through a dot-product job.
// Columns are issued MSB-first, then a single bubble cycle drains the MAC pipeline, then the result is held for the consumer.
module mac_column_sequencer #(
   parameter int MAX_COLS  = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           cfg_num_cols,
   input  logic                 cfg_accum_prev,
   input  logic                 cfg_pool,
   output logic                 busy,
   input  logic                 col_valid,
   output logic                 col_ready,
   output logic                 mac_en,
   output logic                 mac_load_accum,
   output logic                 mac_bubble,
   output logic [$clog2(MAX_COLS)-1:0] mac_column_idx,
   output logic                 mac_is_msb,
   output logic                 mac_is_pooling,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   localparam int IDX_W = $clog2(MAX_COLS);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     col_q, col_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic                 accum_q, accum_d;
   logic                 pool_q, pool_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;

   logic [3:0]           n_eff;
   logic [IDX_W-1:0]     first_col;

   // A column count of 0 runs one column; anything above MAX_COLS is clamped.
   always_comb begin
      n_eff = cfg_num_cols;
      if (cfg_num_cols == 4'd0) begin
         n_eff = 4'd1;
      end else if (cfg_num_cols > 4'(MAX_COLS)) begin
         n_eff = 4'(MAX_COLS);
      end
      first_col = IDX_W'(n_eff - 4'd1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         col_q   <= '0;
         last_q  <= '0;
         accum_q <= 1'b0;
         pool_q  <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         last_q  <= last_d;
         accum_q <= accum_d;
         pool_q  <= pool_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      col_d          = col_q;
      last_d         = last_q;
      accum_d        = accum_q;
      pool_d         = pool_q;
      stall_d        = stall_q;
      col_ready      = 1'b0;
      mac_en         = 1'b0;
      mac_load_accum = 1'b0;
      mac_bubble     = 1'b0;
      mac_is_msb     = 1'b0;
      mac_is_pooling = 1'b0;
      result_valid   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               col_d   = first_col;
               last_d  = first_col;
               accum_d = cfg_accum_prev;
               pool_d  = cfg_pool;
               stall_d = '0;
            end
         end
         RUN: begin
            col_ready  = 1'b1;
            mac_is_msb = (col_q == last_q);
            if (col_valid) begin
               mac_en         = 1'b1;
               mac_load_accum = accum_q && (col_q == last_q);
               if (col_q == '0) begin
                  state_d = DRAIN;
               end else begin
                  col_d = col_q - IDX_W'(1);
               end
            end else if (stall_q != '1) begin
               stall_d = stall_q + CNT_WIDTH'(1);
            end
         end
         DRAIN: begin
            mac_en     = 1'b1;
            mac_bubble = 1'b1;
            state_d    = DONE;
         end
         DONE: begin
            result_valid   = 1'b1;
            mac_is_pooling = pool_q;
            if (result_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy           = (state_q != IDLE);
   assign mac_column_idx = col_q;
   assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_mac_column_sequencer.sv
// Directed testbench for mac_column_sequencer: walks whole jobs cycle by cycle
// and compares every control pin against hand-derived expectations.
module tb_mac_column_sequencer;

   logic        clk;
   logic        resetN;
   logic        start;
   logic [3:0]  cfgNumCols;
   logic        cfgAccumPrev;
   logic        cfgPool;
   logic        busy;
   logic        colValid;
   logic        colReady;
   logic        macEn;
   logic        macLoadAccum;
   logic        macBubble;
   logic [2:0]  macColumnIdx;
   logic        macIsMsb;
   logic        macIsPooling;
   logic        resultValid;
   logic        resultReady;
   logic [15:0] stallCnt;

   int totalChecks;
   int badChecks;

   mac_column_sequencer #(
      .MAX_COLS (8),
      .CNT_WIDTH(16)
   ) dut (
      .clk           (clk),
      .reset         (resetN),
      .start         (start),
      .cfg_num_cols  (cfgNumCols),
      .cfg_accum_prev(cfgAccumPrev),
      .cfg_pool      (cfgPool),
      .busy          (busy),
      .col_valid     (colValid),
      .col_ready     (colReady),
      .mac_en        (macEn),
      .mac_load_accum(macLoadAccum),
      .mac_bubble    (macBubble),
      .mac_column_idx(macColumnIdx),
      .mac_is_msb    (macIsMsb),
      .mac_is_pooling(macIsPooling),
      .result_valid  (resultValid),
      .result_ready  (resultReady),
      .stall_cnt     (stallCnt)
   );

   // Free-running 10-unit clock; inputs change on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [3:0] cols, input logic accum,
                                input logic pool, input logic cv, input logic rr);
      start        = st;
      cfgNumCols   = cols;
      cfgAccumPrev = accum;
      cfgPool      = pool;
      colValid     = cv;
      resultReady  = rr;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Everything quiescent, as after reset or between jobs.
   task automatic checkIdle(input string tag);
      checkOutput({tag, "_busy"},   32'(busy),         32'd0);
      checkOutput({tag, "_ready"},  32'(colReady),     32'd0);
      checkOutput({tag, "_en"},     32'(macEn),        32'd0);
      checkOutput({tag, "_load"},   32'(macLoadAccum), 32'd0);
      checkOutput({tag, "_bubble"}, 32'(macBubble),    32'd0);
      checkOutput({tag, "_idx"},    32'(macColumnIdx), 32'd0);
      checkOutput({tag, "_msb"},    32'(macIsMsb),     32'd0);
      checkOutput({tag, "_pool"},   32'(macIsPooling), 32'd0);
      checkOutput({tag, "_rv"},     32'(resultValid),  32'd0);
   endtask

   // Runs one job from start acceptance to handshake. expN is the effective column
   // count; stallLen cycles of col_valid=0 are inserted after stallAt issues.
   task automatic runJob(input string tag, input logic [3:0] cols, input int expN, input logic accum,
                         input logic pool, input int stallAt, input int stallLen, input int doneHold);
      int issued;
      int stalls;
      int guard;
      applyStimulus(1'b1, cols, accum, pool, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      issued = 0;
      stalls = 0;
      guard  = 0;
      while (issued < expN && guard < 40) begin
         colValid = !(issued == stallAt && stalls < stallLen);
         #1;
         checkOutput({tag, "_run_busy"},  32'(busy),         32'd1);
         checkOutput({tag, "_run_ready"}, 32'(colReady),     32'd1);
         checkOutput({tag, "_run_idx"},   32'(macColumnIdx), 32'(expN - 1 - issued));
         checkOutput({tag, "_run_msb"},   32'(macIsMsb),     32'(issued == 0));
         checkOutput({tag, "_run_rv"},    32'(resultValid),  32'd0);
         if (colValid) begin
            checkOutput({tag, "_run_en"},   32'(macEn),        32'd1);
            checkOutput({tag, "_run_load"}, 32'(macLoadAccum), 32'(accum && issued == 0));
            checkOutput({tag, "_run_bub"},  32'(macBubble),    32'd0);
            issued++;
         end else begin
            checkOutput({tag, "_stall_en"},   32'(macEn),        32'd0);
            checkOutput({tag, "_stall_load"}, 32'(macLoadAccum), 32'd0);
            stalls++;
         end
         nextCycle();
         guard++;
      end

      // DRAIN: col_valid is held high to confirm it is ignored here.
      colValid = 1'b1;
      #1;
      checkOutput({tag, "_drain_bub"},   32'(macBubble),    32'd1);
      checkOutput({tag, "_drain_en"},    32'(macEn),        32'd1);
      checkOutput({tag, "_drain_load"},  32'(macLoadAccum), 32'd0);
      checkOutput({tag, "_drain_ready"}, 32'(colReady),     32'd0);
      checkOutput({tag, "_drain_rv"},    32'(resultValid),  32'd0);
      checkOutput({tag, "_stallcnt"},    32'(stallCnt),     32'(stallLen));
      nextCycle();

      // DONE: held until result_ready, with start pulses that must be ignored.
      for (int j = 0; j <= doneHold; j++) begin
         applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, (j == doneHold));
         #1;
         checkOutput({tag, "_done_rv"},   32'(resultValid),  32'd1);
         checkOutput({tag, "_done_pool"}, 32'(macIsPooling), 32'(pool));
         checkOutput({tag, "_done_busy"}, 32'(busy),         32'd1);
         checkOutput({tag, "_done_en"},   32'(macEn),        32'd0);
         checkOutput({tag, "_done_bub"},  32'(macBubble),    32'd0);
         checkOutput({tag, "_done_idx"},  32'(macColumnIdx), 32'd0);
         nextCycle();
      end
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      checkIdle({tag, "_after"});
      nextCycle();
      colValid = 1'b0;
      checkOutput({tag, "_nostart_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      totalChecks = 0;
      badChecks   = 0;
      resetN      = 1'b0;
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #12;
      checkIdle("reset");
      checkOutput("reset_stall", 32'(stallCnt), 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      nextCycle();

      // col_valid in IDLE must not be consumed.
      colValid = 1'b1;
      #1;
      checkIdle("idle_cv");
      nextCycle();
      colValid = 1'b0;

      $display("[TB] N=8 plain job");
      runJob("n8", 4'd8, 8, 1'b0, 1'b0, 99, 0, 0);
      $display("[TB] N=4 accumulate from previous");
      runJob("acc4", 4'd4, 4, 1'b1, 1'b0, 99, 0, 0);
      $display("[TB] N=4 with 3-cycle stall");
      runJob("stall4", 4'd4, 4, 1'b0, 1'b0, 2, 3, 0);
      $display("[TB] DONE held 5 cycles, pooling");
      runJob("hold", 4'd3, 3, 1'b0, 1'b1, 99, 0, 5);
      $display("[TB] clamp cases");
      runJob("n0", 4'd0, 1, 1'b1, 1'b0, 99, 0, 0);
      runJob("n15", 4'd15, 8, 1'b0, 1'b1, 99, 0, 1);

      // Reset while sitting at column 5 after one stall.
      $display("[TB] reset mid-job");
      applyStimulus(1'b1, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      nextCycle();
      nextCycle();
      colValid = 1'b0;
      nextCycle();
      colValid = 1'b1;
      #1;
      checkOutput("midrst_pre_idx",   32'(macColumnIdx), 32'd5);
      checkOutput("midrst_pre_stall", 32'(stallCnt),     32'd1);
      resetN = 1'b0;
      #1;
      checkIdle("midrst");
      checkOutput("midrst_stall", 32'(stallCnt), 32'd0);
      @(negedge clk);
      resetN   = 1'b1;
      colValid = 1'b0;
      nextCycle();
      runJob("postrst", 4'd6, 6, 1'b1, 1'b0, 0, 2, 0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
